// File: rtl/aibcr3_red_pkg.sv
// Shared types and helpers for the AIB column redundancy shift controller.
// Holds the sequencer state encoding, quiet-counter width and thermometer target function.
package aibcr3_red_pkg;

  localparam int unsigned QCNT_W     = 8;
  localparam int unsigned RED_MAX_IO = 64;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GATE   = 3'd1,
    ST_SWITCH = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DONE   = 3'd4
  } red_state_e;

  // Lanes at or above the failing index shift over; lanes past num_io stay clear.
  function automatic logic [RED_MAX_IO-1:0] red_therm(input logic        en,
                                                       input int unsigned idx,
                                                       input int unsigned num_io);
    logic [RED_MAX_IO-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < RED_MAX_IO; i++) begin
      v[i[5:0]] = en && (i >= idx) && (i < num_io);
    end
    return v;
  endfunction

endpackage

// File: rtl/aibcr3_red_shift_ctrl_if.sv
// Configuration handshake bundle for the redundancy shift controller.
interface aibcr3_red_shift_ctrl_if #(
  parameter int unsigned IDX_W = 5
);
  logic             red_cfg_vld;
  logic             red_cfg_rdy;
  logic             red_cfg_en;
  logic [IDX_W-1:0] red_cfg_idx;

  modport master (
    output red_cfg_vld,
    output red_cfg_en,
    output red_cfg_idx,
    input  red_cfg_rdy
  );

  modport slave (
    input  red_cfg_vld,
    input  red_cfg_en,
    input  red_cfg_idx,
    output red_cfg_rdy
  );
endinterface

// File: rtl/aibcr3_red_quiet_cnt.sv
// Load/decrement down-counter timing the clock-quiet windows around a mux switch.
module aibcr3_red_quiet_cnt
  import aibcr3_red_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [QCNT_W-1:0] load_val,
  input  logic              dec,
  output logic              zero
);

  logic [QCNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - QCNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/aibcr3_red_shift_ctrl.sv
// Redundancy shift_en sequencer: mux selects only move while column clocks are quiet.
// Optional JTAG override of shift_en when AIBCR3_RED_JTAG_OVR_EN is defined.
//
//   state  | meaning
//   IDLE   | ready for a configuration, clocks running
//   GATE   | clocks held quiet before the mux switch
//   SWITCH | shift_en loads the new target at the end of this cycle
//   SETTLE | clocks still held quiet while the muxes settle
//   DONE   | clocks released, completion pulse
module aibcr3_red_shift_ctrl
  import aibcr3_red_pkg::*;
#(
  parameter int unsigned NUM_IO    = 24,
  parameter int unsigned IDX_W     = 5,
  parameter int unsigned QUIET_CYC = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
`ifdef AIBCR3_RED_JTAG_OVR_EN
  input  logic                      jtag_ovr_en,
  input  logic [NUM_IO-1:0]         jtag_shift_en,
`endif
  aibcr3_red_shift_ctrl_if.slave    cfg,
  output logic [NUM_IO-1:0]         shift_en,
  output logic                      clk_gate_n,
  output logic                      busy,
  output logic                      red_done,
  output logic                      red_err
);

  localparam logic [QCNT_W-1:0] QLOAD = QCNT_W'(QUIET_CYC - 1);

  red_state_e        state_q, state_d;
  logic [NUM_IO-1:0] shift_en_q, shift_en_d;
  logic [NUM_IO-1:0] tgt_q, tgt_d, tgt_new;
  logic              clk_gate_n_q, clk_gate_n_d;
  logic              busy_q, busy_d;
  logic              red_done_q, red_done_d;
  logic              red_err_q, red_err_d;
  logic [IDX_W-1:0]  idx_s;
  logic              rdy, xfer, cfg_bad, nochg, seq_gated;
  logic              cnt_load, cnt_dec, cnt_zero;

  assign idx_s   = cfg.red_cfg_idx;
  assign tgt_new = NUM_IO'(red_therm(cfg.red_cfg_en, 32'(idx_s), NUM_IO));
  assign cfg_bad = cfg.red_cfg_en && (32'(idx_s) >= NUM_IO);

`ifdef AIBCR3_RED_JTAG_OVR_EN
  assign rdy = (state_q == ST_IDLE) && !jtag_ovr_en;
`else
  assign rdy = (state_q == ST_IDLE);
`endif
  assign xfer = cfg.red_cfg_vld && rdy;

  aibcr3_red_quiet_cnt u_quiet_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (QLOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d    = state_q;
    shift_en_d = shift_en_q;
    tgt_d      = tgt_q;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    nochg      = 1'b0;
    red_err_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          if (cfg_bad) begin
            red_err_d = 1'b1;
          end else if (tgt_new == shift_en_q) begin
            nochg = 1'b1;
          end else begin
            tgt_d    = tgt_new;
            cnt_load = 1'b1;
            state_d  = ST_GATE;
          end
        end
      end
      ST_GATE: begin
        if (cnt_zero) state_d = ST_SWITCH;
        else          cnt_dec = 1'b1;
      end
      ST_SWITCH: begin
        shift_en_d = tgt_q;
        cnt_load   = 1'b1;
        state_d    = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_zero) state_d = ST_DONE;
        else          cnt_dec = 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

`ifdef AIBCR3_RED_JTAG_OVR_EN
    // Tester owns the muxes with its clock stopped, so no quiet sequence is needed.
    if (jtag_ovr_en) begin
      state_d    = ST_IDLE;
      shift_en_d = jtag_shift_en;
      cnt_load   = 1'b0;
      cnt_dec    = 1'b0;
      nochg      = 1'b0;
      red_err_d  = 1'b0;
    end
`endif

    seq_gated    = state_d inside {ST_GATE, ST_SWITCH, ST_SETTLE};
    clk_gate_n_d = !seq_gated;
    busy_d       = seq_gated;
    red_done_d   = nochg || (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      shift_en_q   <= '0;
      tgt_q        <= '0;
      clk_gate_n_q <= 1'b1;
      busy_q       <= 1'b0;
      red_done_q   <= 1'b0;
      red_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_en_q   <= shift_en_d;
      tgt_q        <= tgt_d;
      clk_gate_n_q <= clk_gate_n_d;
      busy_q       <= busy_d;
      red_done_q   <= red_done_d;
      red_err_q    <= red_err_d;
    end
  end

  assign cfg.red_cfg_rdy = rdy;
  assign shift_en        = shift_en_q;
  assign clk_gate_n      = clk_gate_n_q;
  assign busy            = busy_q;
  assign red_done        = red_done_q;
  assign red_err         = red_err_q;

endmodule

// File: tb/tb_aibcr3_red_shift_ctrl.sv
// Bench for aibcr3_red_shift_ctrl: timeline model of the quiet/switch sequence plus directed pins.
module tb_aibcr3_red_shift_ctrl;

  localparam int NUM = 24;
  localparam int Q   = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aibcr3_red_shift_ctrl_if #(.IDX_W(5)) cfg_if ();

  logic [NUM-1:0] shift_en;
  logic           clk_gate_n, busy, red_done, red_err;
`ifdef AIBCR3_RED_JTAG_OVR_EN
  logic           jtag_ovr_en   = 1'b0;
  logic [NUM-1:0] jtag_shift_en = '0;
`endif

  aibcr3_red_shift_ctrl #(.NUM_IO(NUM), .IDX_W(5), .QUIET_CYC(Q)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
`ifdef AIBCR3_RED_JTAG_OVR_EN
    .jtag_ovr_en   (jtag_ovr_en),
    .jtag_shift_en (jtag_shift_en),
`endif
    .cfg           (cfg_if),
    .shift_en      (shift_en),
    .clk_gate_n    (clk_gate_n),
    .busy          (busy),
    .red_done      (red_done),
    .red_err       (red_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Target as plain arithmetic: the top NUM-idx lanes set.
  function automatic logic [NUM-1:0] target(input logic en, input int idx);
    longint unsigned v;
    v = en ? ((64'd1 << NUM) - (64'd1 << idx)) : 64'd0;
    return v[NUM-1:0];
  endfunction

  // Model: age = cycles since the accepting edge (0 = idle); outputs follow the timeline.
  int             m_age;
  logic [NUM-1:0] m_shift, m_tgt;
  logic           m_nc, m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_age = 0; m_shift = '0; m_tgt = '0; m_nc = 0; m_err = 0;
    end else begin
      m_nc  = 0;
      m_err = 0;
      if (m_age != 0) begin
        if (m_age == Q + 1) m_shift = m_tgt;
        m_age = (m_age == 2*Q + 2) ? 0 : m_age + 1;
      end else if (cfg_if.red_cfg_vld) begin
        if (cfg_if.red_cfg_en && int'(cfg_if.red_cfg_idx) >= NUM) m_err = 1;
        else if (target(cfg_if.red_cfg_en, int'(cfg_if.red_cfg_idx)) == m_shift) m_nc = 1;
        else begin
          m_tgt = target(cfg_if.red_cfg_en, int'(cfg_if.red_cfg_idx));
          m_age = 1;
        end
      end
    end
  end

  logic [NUM-1:0] prev_shift;
  logic           prev_ok = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      logic exp_gate;
      exp_gate = !(m_age >= 1 && m_age <= 2*Q + 1);
      chk("shift_en",    32'(shift_en),           32'(m_shift));
      chk("clk_gate_n",  32'(clk_gate_n),         32'(exp_gate));
      chk("busy",        32'(busy),               32'(!exp_gate));
      chk("red_done",    32'(red_done),           32'((m_age == 2*Q + 2) || m_nc));
      chk("red_err",     32'(red_err),            32'(m_err));
      chk("red_cfg_rdy", 32'(cfg_if.red_cfg_rdy), 32'(m_age == 0));
      if (prev_ok && shift_en != prev_shift) chk("shift_while_clk_on", 32'(clk_gate_n), 32'(0));
      prev_shift = shift_en;
      prev_ok    = 1'b1;
    end else begin
      prev_ok = 1'b0;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic en, input logic [4:0] idx, output int n_wait);
    @(negedge clk);
    cfg_if.red_cfg_vld = 1'b1;
    cfg_if.red_cfg_en  = en;
    cfg_if.red_cfg_idx = idx;
    n_wait = 0;
    while (!cfg_if.red_cfg_rdy && n_wait < 200) begin
      @(negedge clk);
      n_wait++;
    end
    if (n_wait >= 200) chk("send_timeout", 32'(n_wait), 32'(0));
    @(posedge clk);
    @(negedge clk);
    cfg_if.red_cfg_vld = 1'b0;
  endtask

  initial begin
    #2_000_000;
    total++;
    bad++;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int nw;
    cfg_if.red_cfg_vld = 1'b0;
    cfg_if.red_cfg_en  = 1'b0;
    cfg_if.red_cfg_idx = '0;
    wait_cyc(3);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_shift", 32'(shift_en), 32'h000000);
    chk("rst_gate",  32'(clk_gate_n), 32'(1));
    chk("rst_rdy",   32'(cfg_if.red_cfg_rdy), 32'(1));
    chk("rst_pulse", 32'({red_done, red_err, busy}), 32'(0));

    // en=1 idx=5: exact timeline pins
    send(1'b1, 5'd5, nw);
    chk("t1_gate", 32'(clk_gate_n), 32'(0));
    wait_cyc(8);
    chk("t9_shift_old", 32'(shift_en), 32'h000000);
    wait_cyc(1);
    chk("t10_shift", 32'(shift_en), 32'hFFFFE0);
    wait_cyc(8);
    chk("t18_done", 32'(red_done), 32'(1));
    chk("t18_gate", 32'(clk_gate_n), 32'(1));
    wait_cyc(1);
    chk("t19_rdy", 32'(cfg_if.red_cfg_rdy), 32'(1));

    // out-of-range index rejected
    send(1'b1, 5'd30, nw);
    chk("rej_err",   32'(red_err), 32'(1));
    chk("rej_shift", 32'(shift_en), 32'hFFFFE0);
    wait_cyc(2);

    // same config: immediate done, no gating
    send(1'b1, 5'd5, nw);
    chk("nc_done", 32'(red_done), 32'(1));
    chk("nc_gate", 32'(clk_gate_n), 32'(1));
    wait_cyc(2);

    send(1'b0, 5'd0, nw);
    wait_cyc(19);
    chk("dis_shift", 32'(shift_en), 32'h000000);

    // request held during SETTLE is only taken once ready returns
    send(1'b1, 5'd5, nw);
    wait_cyc(11);
    send(1'b1, 5'd0, nw);
    chk("held_wait", 32'(nw), 32'(6));
    wait_cyc(18);
    chk("idx0_shift", 32'(shift_en), 32'hFFFFFF);

    // asynchronous reset in GATE
    send(1'b0, 5'd0, nw);
    wait_cyc(2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_shift", 32'(shift_en), 32'h000000);
    chk("arst_gate",  32'(clk_gate_n), 32'(1));
    chk("arst_busy",  32'(busy), 32'(0));
    chk("arst_rdy",   32'(cfg_if.red_cfg_rdy), 32'(1));
    @(negedge clk);
    #1 rst_n = 1'b1;

    for (int k = 0; k < 40; k++) begin
      send(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), nw);
      wait_cyc($urandom_range(0, 25));
    end
    wait_cyc(25);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
